// File: rtl/focus_metric_af_if.sv
// Bundles the pixel stream, autofocus controls and result signals exchanged
// between the edge-filter pipeline and the focus-metric / autofocus block.
interface focus_metric_af_if #(
   parameter int POS_W = 4
);
   logic [7:0]       edge_mag;
   logic             pix_valid;
   logic             hs;
   logic             vs;
   logic             start;
   logic             af_enable;
   logic [31:0]      frame_metric;
   logic             metric_valid;
   logic [POS_W-1:0] lens_pos;
   logic [31:0]      best_metric;
   logic             af_busy;
   logic             af_done;

   // Upstream side: drives pixels and controls, observes results.
   modport master (
      output edge_mag, pix_valid, hs, vs, start, af_enable,
      input  frame_metric, metric_valid, lens_pos, best_metric, af_busy, af_done
   );

   // Focus block side.
   modport slave (
      input  edge_mag, pix_valid, hs, vs, start, af_enable,
      output frame_metric, metric_valid, lens_pos, best_metric, af_busy, af_done
   );
endinterface

// File: rtl/focus_metric_af.sv
// Focus metric and full-sweep autofocus controller.
// Tracks pixel coordinates from the filtered VGA timing, sums thresholded
// Sobel magnitude inside a window once per frame, and steps the lens through
// every position, settling for a few frames before measuring each one, then
// parks the lens at the sharpest position found.
module focus_metric_af #(
   parameter int WIN_X0        = 200,
   parameter int WIN_Y0        = 120,
   parameter int WIN_W         = 400,
   parameter int WIN_H         = 240,
   parameter int THRESH        = 16,
   parameter int SETTLE_FRAMES = 2,
   parameter int POS_W         = 4,
   parameter int MAX_POS       = 15
) (
   input logic              VGA_CLK,
   input logic              reset,
   focus_metric_af_if.slave bus
);

   localparam int CNT_W = $clog2(SETTLE_FRAMES + 1) + 1;

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

   logic             hs_q, vs_q;
   logic [11:0]      x_q, x_d;
   logic [10:0]      y_q, y_d;
   logic             lineHad_q, lineHad_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      frameMetric_q;
   logic             metricValid_q;
   state_t           state_q;
   logic [POS_W-1:0] lensPos_q, bestPos_q;
   logic [31:0]      bestMetric_q;
   logic [CNT_W-1:0] settleCnt_q;
   logic             afBusy_q, afDone_q;

   logic             hsFall, vsFall, inWin, accept, better;
   logic [32:0]      accSum;
   logic [POS_W-1:0] newBestPos;

   // Next-state logic for the coordinate counters and the window accumulator.
   always_comb begin
      hsFall     = hs_q & ~bus.hs;
      vsFall     = vs_q & ~bus.vs;
      inWin      = ({20'd0, x_q} >= 32'(WIN_X0)) && ({20'd0, x_q} < 32'(WIN_X0 + WIN_W)) &&
                   ({21'd0, y_q} >= 32'(WIN_Y0)) && ({21'd0, y_q} < 32'(WIN_Y0 + WIN_H));
      accept     = bus.pix_valid & inWin & (bus.edge_mag >= 8'(THRESH)) & ~vsFall;
      accSum     = {1'b0, acc_q} + {25'd0, bus.edge_mag};
      better     = acc_q > bestMetric_q;
      newBestPos = better ? lensPos_q : bestPos_q;

      x_d = x_q;
      if (hsFall)
         x_d = 12'd0;
      else if (bus.pix_valid)
         x_d = x_q + 12'd1;

      lineHad_d = lineHad_q;
      if (hsFall)
         lineHad_d = 1'b0;
      else if (bus.pix_valid)
         lineHad_d = 1'b1;

      y_d = y_q;
      if (vsFall)
         y_d = 11'd0;
      else if (hsFall && lineHad_q)
         y_d = y_q + 11'd1;

      acc_d = acc_q;
      if (vsFall)
         acc_d = 32'd0;
      else if (accept)
         acc_d = accSum[32] ? 32'hFFFF_FFFF : accSum[31:0];
   end

   // Metric path: sync history, coordinates, accumulator and per-frame result.
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         lineHad_q     <= 1'b0;
         acc_q         <= '0;
         frameMetric_q <= '0;
         metricValid_q <= 1'b0;
      end else begin
         hs_q          <= bus.hs;
         vs_q          <= bus.vs;
         x_q           <= x_d;
         y_q           <= y_d;
         lineHad_q     <= lineHad_d;
         acc_q         <= acc_d;
         metricValid_q <= vsFall;
         if (vsFall)
            frameMetric_q <= acc_q;
      end
   end

   // Autofocus sweep: settle after each lens move, measure, keep the best.
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         state_q      <= IDLE;
         lensPos_q    <= '0;
         bestPos_q    <= '0;
         bestMetric_q <= '0;
         settleCnt_q  <= '0;
         afBusy_q     <= 1'b0;
         afDone_q     <= 1'b0;
      end else if (!bus.af_enable) begin
         state_q  <= IDLE;
         afBusy_q <= 1'b0;
         afDone_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  lensPos_q    <= '0;
                  bestPos_q    <= '0;
                  bestMetric_q <= '0;
                  settleCnt_q  <= '0;
                  state_q      <= SETTLE;
                  afBusy_q     <= 1'b1;
                  afDone_q     <= 1'b0;
               end
            end
            SETTLE: begin
               if (vsFall) begin
                  settleCnt_q <= settleCnt_q + 1'b1;
                  if (settleCnt_q == CNT_W'(SETTLE_FRAMES - 1))
                     state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (vsFall) begin
                  if (better) begin
                     bestMetric_q <= acc_q;
                     bestPos_q    <= lensPos_q;
                  end
                  if (lensPos_q == POS_W'(MAX_POS)) begin
                     lensPos_q <= newBestPos;
                     state_q   <= DONE;
                     afBusy_q  <= 1'b0;
                     afDone_q  <= 1'b1;
                  end else begin
                     lensPos_q   <= lensPos_q + 1'b1;
                     settleCnt_q <= '0;
                     state_q     <= SETTLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.frame_metric = frameMetric_q;
   assign bus.metric_valid = metricValid_q;
   assign bus.lens_pos     = lensPos_q;
   assign bus.best_metric  = bestMetric_q;
   assign bus.af_busy      = afBusy_q;
   assign bus.af_done      = afDone_q;

endmodule

// File: tb/tb_focus_metric_af.sv
// Testbench for focus_metric_af: small 16x8 frames, a scoreboard of expected
// frame metrics popped on every metric_valid pulse, plus direct checks of the
// autofocus sweep, abort and reset behaviour.
module tb_focus_metric_af;

   logic VGA_CLK = 1'b0;
   logic reset   = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [31:0] expQ[$];
   logic        monitorOn = 1'b0;
   logic        mvPrev    = 1'b0;

   int metricTbl[4] = '{100, 300, 300, 50};

   focus_metric_af_if #(.POS_W(4)) bus ();

   focus_metric_af #(
      .WIN_X0(4), .WIN_Y0(2), .WIN_W(8), .WIN_H(4), .THRESH(16),
      .SETTLE_FRAMES(1), .POS_W(4), .MAX_POS(3)
   ) dut (
      .VGA_CLK(VGA_CLK),
      .reset(reset),
      .bus(bus)
   );

   // Free-running pixel clock.
   always #5 VGA_CLK = ~VGA_CLK;

   // Compares one observed value against its expected value and tallies it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge VGA_CLK);
   endtask

   // Drives one 16x8 frame followed by a vs low period. In target mode the
   // window pixels carry the target sum spread in chunks of at most 255 and
   // every pixel outside the window carries 255.
   task automatic applyStimulus(input bit useTarget, input logic [7:0] constMag,
                                input int target, input logic [31:0] expMetric);
      int rem;
      bit inWin;
      rem = target;
      for (int row = 0; row < 8; row++) begin
         bus.hs = 1'b1;
         idleCycles(2);
         for (int col = 0; col < 16; col++) begin
            inWin = (col >= 4) && (col < 12) && (row >= 2) && (row < 6);
            bus.pix_valid = 1'b1;
            if (!useTarget)
               bus.edge_mag = constMag;
            else if (!inWin)
               bus.edge_mag = 8'd255;
            else begin
               bus.edge_mag = (rem > 255) ? 8'd255 : 8'(rem);
               rem -= int'(bus.edge_mag);
            end
            @(negedge VGA_CLK);
         end
         bus.pix_valid = 1'b0;
         bus.edge_mag  = 8'd0;
         idleCycles(2);
         bus.hs = 1'b0;
         idleCycles(2);
      end
      bus.hs = 1'b1;
      idleCycles(2);
      bus.vs = 1'b0;
      expQ.push_back(expMetric);
      idleCycles(3);
      bus.vs = 1'b1;
      idleCycles(3);
   endtask

   task automatic pulseStart();
      bus.start = 1'b1;
      @(negedge VGA_CLK);
      bus.start = 1'b0;
   endtask

   // Scoreboard: every metric_valid pulse pops one expected frame metric.
   always @(negedge VGA_CLK) begin
      if (monitorOn) begin
         if (mvPrev)
            checkOutput("metricValidWidth", {31'd0, bus.metric_valid}, 32'd0);
         if (bus.metric_valid === 1'b1) begin
            if (expQ.size() == 0)
               checkOutput("unexpectedMetric", 32'd1, 32'd0);
            else
               checkOutput("frameMetric", bus.frame_metric, expQ.pop_front());
         end
         mvPrev = (bus.metric_valid === 1'b1);
      end
   end

   // Guard against a hung run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   // Main sequence.
   initial begin
      bus.edge_mag  = 8'd0;
      bus.pix_valid = 1'b0;
      bus.hs        = 1'b1;
      bus.vs        = 1'b1;
      bus.start     = 1'b0;
      bus.af_enable = 1'b0;
      reset         = 1'b1;
      idleCycles(3);
      reset = 1'b0;
      checkOutput("rstFrameMetric", bus.frame_metric, 32'd0);
      checkOutput("rstMetricValid", {31'd0, bus.metric_valid}, 32'd0);
      checkOutput("rstLensPos", {28'd0, bus.lens_pos}, 32'd0);
      checkOutput("rstBestMetric", bus.best_metric, 32'd0);
      checkOutput("rstBusy", {31'd0, bus.af_busy}, 32'd0);
      checkOutput("rstDone", {31'd0, bus.af_done}, 32'd0);
      monitorOn = 1'b1;

      // Empty frame end to align with the frame timing.
      idleCycles(2);
      bus.vs = 1'b0;
      expQ.push_back(32'd0);
      idleCycles(3);
      bus.vs = 1'b1;
      idleCycles(3);

      // Window sum and threshold boundary.
      applyStimulus(1'b0, 8'd20, 0, 32'd640);
      applyStimulus(1'b0, 8'd15, 0, 32'd0);
      applyStimulus(1'b0, 8'd16, 0, 32'd512);

      // Saturation from a preloaded accumulator.
      force dut.acc_q = 32'hFFFF_FF00;
      #1;
      release dut.acc_q;
      applyStimulus(1'b0, 8'd255, 0, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 8'd20, 0, 32'd640);

      // Full sweep over four positions, one settle frame each.
      bus.af_enable = 1'b1;
      pulseStart();
      checkOutput("sweepStartPos", {28'd0, bus.lens_pos}, 32'd0);
      checkOutput("sweepStartBusy", {31'd0, bus.af_busy}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 8'd0, metricTbl[k], 32'(metricTbl[k]));
         applyStimulus(1'b1, 8'd0, metricTbl[k], 32'(metricTbl[k]));
         checkOutput("sweepBest", bus.best_metric, (k == 0) ? 32'd100 : 32'd300);
         if (k < 3) begin
            checkOutput("sweepPos", {28'd0, bus.lens_pos}, 32'(k + 1));
            checkOutput("sweepBusy", {31'd0, bus.af_busy}, 32'd1);
         end
         if (k == 0) begin
            pulseStart();
            checkOutput("startIgnoredPos", {28'd0, bus.lens_pos}, 32'd1);
         end
      end
      checkOutput("sweepDone", {31'd0, bus.af_done}, 32'd1);
      checkOutput("sweepDoneBusy", {31'd0, bus.af_busy}, 32'd0);
      checkOutput("sweepFinalPos", {28'd0, bus.lens_pos}, 32'd1);
      checkOutput("sweepFinalBest", bus.best_metric, 32'd300);

      // Restart from DONE, then abort while settling at position 2.
      pulseStart();
      checkOutput("restartPos", {28'd0, bus.lens_pos}, 32'd0);
      checkOutput("restartBest", bus.best_metric, 32'd0);
      checkOutput("restartDone", {31'd0, bus.af_done}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 8'd0, metricTbl[k], 32'(metricTbl[k]));
         applyStimulus(1'b1, 8'd0, metricTbl[k], 32'(metricTbl[k]));
      end
      checkOutput("abortPrePos", {28'd0, bus.lens_pos}, 32'd2);
      bus.af_enable = 1'b0;
      @(negedge VGA_CLK);
      checkOutput("abortBusy", {31'd0, bus.af_busy}, 32'd0);
      checkOutput("abortDone", {31'd0, bus.af_done}, 32'd0);
      checkOutput("abortPos", {28'd0, bus.lens_pos}, 32'd2);
      checkOutput("abortBest", bus.best_metric, 32'd300);
      pulseStart();
      idleCycles(1);
      checkOutput("disabledStartBusy", {31'd0, bus.af_busy}, 32'd0);
      checkOutput("disabledStartPos", {28'd0, bus.lens_pos}, 32'd2);

      // Reset while measuring, then restart.
      bus.af_enable = 1'b1;
      pulseStart();
      applyStimulus(1'b1, 8'd0, 100, 32'd100);
      checkOutput("measureBusy", {31'd0, bus.af_busy}, 32'd1);
      reset = 1'b1;
      @(negedge VGA_CLK);
      reset = 1'b0;
      checkOutput("midRstFrameMetric", bus.frame_metric, 32'd0);
      checkOutput("midRstLensPos", {28'd0, bus.lens_pos}, 32'd0);
      checkOutput("midRstBest", bus.best_metric, 32'd0);
      checkOutput("midRstBusy", {31'd0, bus.af_busy}, 32'd0);
      checkOutput("midRstDone", {31'd0, bus.af_done}, 32'd0);
      idleCycles(2);
      pulseStart();
      checkOutput("postRstPos", {28'd0, bus.lens_pos}, 32'd0);
      checkOutput("postRstBusy", {31'd0, bus.af_busy}, 32'd1);
      applyStimulus(1'b0, 8'd20, 0, 32'd640);

      idleCycles(4);
      checkOutput("pendingMetrics", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
